// File: rtl/adv7180_i2c_slave_if.sv
// adv7180_i2c_slave_if: two-wire bus lines, write-strobe report and register-file peek
// port shared by the ADV7180 target model and whoever drives the bus.
interface adv7180_i2c_slave_if #(
    parameter int unsigned REG_AW = 8
);
    logic              scl_i;
    logic              sda_i;
    logic              sda_oe;
    logic              wr_stb;
    logic [REG_AW-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [REG_AW-1:0] dbg_addr;
    logic [7:0]        dbg_data;
    logic              busy;

    modport master (
        output scl_i, sda_i, dbg_addr,
        input  sda_oe, wr_stb, wr_addr, wr_data, dbg_data, busy
    );

    modport slave (
        input  scl_i, sda_i, dbg_addr,
        output sda_oe, wr_stb, wr_addr, wr_data, dbg_data, busy
    );
endinterface

// File: rtl/adv7180_i2c_slave.sv
// adv7180_i2c_slave: I2C target modelling the ADV7180 register file with write strobes.
// Define ADV7180_I2C_SLAVE_READ_EN to build read (R/W=1) transfer support.
module adv7180_i2c_slave #(
    parameter logic [6:0]  DEV_ADDR = 7'h20,
    parameter int unsigned REG_AW   = 8
) (
    input logic                i_clk,
    input logic                i_rst_n,
    adv7180_i2c_slave_if.slave bus
);
    localparam int unsigned Depth = 1 << REG_AW;

    typedef enum logic [3:0] {
        StIdle, StAddr, StAckA, StSub, StAckS, StWdata, StAckW, StIgnore
`ifdef ADV7180_I2C_SLAVE_READ_EN
        , StRdata, StMack
`endif
    } state_t;

    logic [1:0]        r_scl_sync, r_sda_sync;
    logic              r_scl_hist, r_sda_hist;
    logic              r_scl_rise, r_scl_fall, r_start, r_stop, r_sda_s;
    state_t            r_state;
    logic [3:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [REG_AW-1:0] r_ptr;
    logic              r_ack_on;
    logic              r_sda_oe, r_wr_stb, r_busy;
    logic [REG_AW-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_rf [Depth];
`ifdef ADV7180_I2C_SLAVE_READ_EN
    logic              r_rw, r_load;
    logic [7:0]        r_tx;
`endif

    logic [7:0] w_byte;
    logic       w_last;
    logic       w_addr_ok;

    assign w_byte = {r_shift[6:0], r_sda_s};
    assign w_last = (r_bit_cnt == 4'd7);
`ifdef ADV7180_I2C_SLAVE_READ_EN
    assign w_addr_ok = (w_byte[7:1] == DEV_ADDR);
`else
    assign w_addr_ok = (w_byte[7:1] == DEV_ADDR) && !w_byte[0];
`endif

    // Idle-high reset on the synchronizers keeps a reset release from looking like an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_sda_s    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], bus.scl_i};
            r_sda_sync <= {r_sda_sync[0], bus.sda_i};
            r_scl_hist <= r_scl_sync[1];
            r_sda_hist <= r_sda_sync[1];
            r_scl_rise <= r_scl_sync[1] & ~r_scl_hist;
            r_scl_fall <= ~r_scl_sync[1] & r_scl_hist;
            r_start    <= r_scl_sync[1] & r_scl_hist & r_sda_hist & ~r_sda_sync[1];
            r_stop     <= r_scl_sync[1] & r_scl_hist & ~r_sda_hist & r_sda_sync[1];
            r_sda_s    <= r_sda_sync[1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_ptr     <= '0;
            r_ack_on  <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'h00;
            r_busy    <= 1'b0;
            for (int unsigned i = 0; i < Depth; i++) r_rf[i] <= 8'h00;
`ifdef ADV7180_I2C_SLAVE_READ_EN
            r_rw      <= 1'b0;
            r_load    <= 1'b0;
            r_tx      <= 8'h00;
`endif
        end else begin
            r_wr_stb <= 1'b0;
            if (r_stop) begin
                r_state  <= StIdle;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
                r_ack_on <= 1'b0;
            end else if (r_start) begin
                r_state   <= StAddr;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b1;
                r_ack_on  <= 1'b0;
            end else begin
                case (r_state)
                    StAddr: if (r_scl_rise) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_last) begin
                            r_state <= w_addr_ok ? StAckA : StIgnore;
`ifdef ADV7180_I2C_SLAVE_READ_EN
                            r_rw    <= w_byte[0];
`endif
                        end
                    end
                    StSub: if (r_scl_rise) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_last) begin
                            r_ptr   <= REG_AW'(w_byte);
                            r_state <= StAckS;
                        end
                    end
                    StWdata: if (r_scl_rise) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_last) begin
                            r_rf[r_ptr] <= w_byte;
                            r_wr_stb    <= 1'b1;
                            r_wr_addr   <= r_ptr;
                            r_wr_data   <= w_byte;
                            r_ptr       <= r_ptr + REG_AW'(1);
                            r_state     <= StAckW;
                        end
                    end
                    // ACK slot: pull low on the first fall, release on the second.
                    StAckA, StAckS, StAckW: if (r_scl_fall) begin
                        if (!r_ack_on) begin
                            r_sda_oe <= 1'b1;
                            r_ack_on <= 1'b1;
                        end else begin
                            r_ack_on  <= 1'b0;
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_state   <= (r_state == StAckA) ? StSub : StWdata;
`ifdef ADV7180_I2C_SLAVE_READ_EN
                            if (r_state == StAckA && r_rw) begin
                                r_state  <= StRdata;
                                r_sda_oe <= ~r_rf[r_ptr][7];
                                r_tx     <= {r_rf[r_ptr][6:0], 1'b0};
                                r_load   <= 1'b0;
                            end
`endif
                        end
                    end
`ifdef ADV7180_I2C_SLAVE_READ_EN
                    StRdata: begin
                        if (r_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (r_scl_fall) begin
                            if (r_load) begin
                                r_sda_oe <= ~r_rf[r_ptr][7];
                                r_tx     <= {r_rf[r_ptr][6:0], 1'b0};
                                r_load   <= 1'b0;
                            end else if (r_bit_cnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= StMack;
                            end else begin
                                r_sda_oe <= ~r_tx[7];
                                r_tx     <= {r_tx[6:0], 1'b0};
                            end
                        end
                    end
                    StMack: if (r_scl_rise) begin
                        if (!r_sda_s) begin
                            r_ptr     <= r_ptr + REG_AW'(1);
                            r_bit_cnt <= 4'd0;
                            r_load    <= 1'b1;
                            r_state   <= StRdata;
                        end else begin
                            r_state <= StIgnore;
                        end
                    end
`endif
                    StIdle, StIgnore: ;
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign bus.sda_oe   = r_sda_oe;
    assign bus.wr_stb   = r_wr_stb;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.busy     = r_busy;
    assign bus.dbg_data = r_rf[bus.dbg_addr];
endmodule
